// File: rtl/reg_file_sb.sv
// Register file with per-register busy/tag scoreboard, two bypassed read ports
// and one write-back port; register 0 is hardwired to zero.
module reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy_in,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [TAG_W-1:0] rs2_tag,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic [TAG_W-1:0] iss_tag,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  output logic [AW:0]      busy_count
);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic [TAG_W-1:0] tag_q [NREG];
  logic [TAG_W-1:0] tag_d [NREG];
  logic [AW:0]      cnt_q, cnt_d;

  logic wb_commit, iss_ok, cnt_inc, cnt_dec;
  logic rs1_hit, rs2_hit;

  // A writeback only counts as committed on an enabled cycle, so the bypass
  // never shows data that the edge will not actually store.
  always_comb begin
    wb_commit = rdy_in && wb_valid && (wb_rd != '0) &&
                (!busy_q[wb_rd] || (tag_q[wb_rd] == wb_tag));
    iss_ok    = rdy_in && iss_valid && (iss_rd != '0) && !flush;
    cnt_inc   = iss_ok && !busy_q[iss_rd];
    cnt_dec   = wb_commit && busy_q[wb_rd] && !(iss_ok && (iss_rd == wb_rd));
  end

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    cnt_d  = cnt_q;
    if (rdy_in) begin
      if (wb_commit) regs_d[wb_rd] = wb_data;
      if (flush) begin
        busy_d = '0;
        for (int i = 0; i < NREG; i++) tag_d[i] = '0;
        cnt_d = '0;
      end else begin
        if (wb_commit) begin
          busy_d[wb_rd] = 1'b0;
          tag_d[wb_rd]  = '0;
        end
        // issue is applied last so it wins over a same-register commit
        if (iss_ok) begin
          busy_d[iss_rd] = 1'b1;
          tag_d[iss_rd]  = iss_tag;
        end
        cnt_d = cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rs1_hit  = wb_commit && (wb_rd == rs1_addr);
    rs2_hit  = wb_commit && (wb_rd == rs2_addr);
    rs1_data = rs1_hit ? wb_data : regs_q[rs1_addr];
    rs2_data = rs2_hit ? wb_data : regs_q[rs2_addr];
    rs1_busy = rs1_hit ? 1'b0 : busy_q[rs1_addr];
    rs2_busy = rs2_hit ? 1'b0 : busy_q[rs2_addr];
    rs1_tag  = rs1_hit ? '0 : tag_q[rs1_addr];
    rs2_tag  = rs2_hit ? '0 : tag_q[rs2_addr];
  end

  assign busy_count = cnt_q;

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with an integrated scoreboard for the pipelined core. It provides two combinational read ports with same-cycle writeback bypass and one write-back port. Per-register busy/tag tracking lets decode detect pending producers, so it does not need to wait for a "finished" pulse. It sits between decode (reads, issue marking) and write back (commit), and is the successor of the single-access register file.

## Interface
- XLEN, 32, data width of each register
- NREG, 32, number of registers; power of two, at least 2; register 0 is hardwired zero
- TAG_W, 4, width of the producer tag attached to an in-flight destination
- AW (derived), clog2(NREG), register index width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- rdy_in  in  1  global enable; 0 freezes all state (issue, writeback, flush ignored); reads stay live
- rs1_addr, rs2_addr  in  AW  read indices
- rs1_data, rs2_data  out  XLEN  read data (combinational, bypassed)
- rs1_busy, rs2_busy  out  1  register has a pending producer after this cycle's writeback
- rs1_tag, rs2_tag  out  TAG_W  tag of the pending producer; 0 when not busy
- iss_valid  in  1  mark iss_rd as pending
- iss_rd  in  AW  destination being issued
- iss_tag  in  TAG_W  producer tag for iss_rd
- wb_valid  in  1  writeback request
- wb_rd  in  AW  writeback destination
- wb_tag  in  TAG_W  tag of the producer writing back
- wb_data  in  XLEN  writeback data
- flush  in  1  clear every busy bit (pipeline squash)
- busy_count  out  AW+1  registered number of busy registers

## Operation
- State:
  - regs[NREG] of XLEN bits
  - busy[NREG] of 1 bit
  - tag[NREG] of TAG_W bits
  - busy_count
- Index 0 behaviour:
  - Always reads data 0, busy 0, tag 0.
  - iss, wb and flush never change it.
- Commit condition for a writeback: wb_valid && wb_rd≠0 && (!busy[wb_rd] || tag[wb_rd]==wb_tag).
  - A stale writeback (busy with a different tag) is dropped entirely: no data write, no busy change.
- On a committing writeback:
  - regs[wb_rd] ← wb_data.
  - busy[wb_rd] ← 0, unless the same register is issued in the same cycle.
- Issue (iss_valid && iss_rd≠0 && !flush): busy[iss_rd] ← 1, tag[iss_rd] ← iss_tag.
  - Issue wins over a same-cycle writeback to the same register for busy and tag.
  - The writeback data is still committed.
- Flush:
  - Clears all busy bits and tags at the edge; iss is ignored that cycle.
  - A committing wb that cycle still writes its data.
- Read port X:
  - If the writeback commits and wb_rd==rsX_addr: data = wb_data, busy = 0, tag = 0 (bypass).
  - Otherwise: data = regs, busy = busy, tag = tag.
  - The same-cycle issue is not reflected on the read port.
- busy_count is updated every enabled edge to the population count of the next busy vector.
  - Range 0..NREG-1.
  - Maintained incrementally: +1 for an issue onto a non-busy register, −1 for a clearing commit, net 0 for both; reset to 0 on flush.

## Timing
- Reset (rst=0, asynchronous):
  - All regs = 0, busy = 0, tag = 0, busy_count = 0.
  - Read outputs therefore 0, busy 0, tag 0 while held.
- Read latency 0: outputs are combinational from addresses plus the current writeback bypass.
- Write, issue and flush take effect at the rising edge; they are visible unbypassed from the next cycle.
- rdy_in=0 at an edge: no state change; busy_count holds.
- Reset asserted mid-operation discards any in-flight issue or writeback; no partial update.

## Test plan
- Reset then read x5: rs1_data=0, busy=0, busy_count=0. Write x5=0xDEADBEEF with not busy, then read → 0xDEADBEEF next cycle; the same cycle returns it via bypass.
- Issue x3 tag 2 → busy_count=1, rs1_busy=1 tag=2. Writeback x3 tag 7 data 0x11 → dropped, still busy. Writeback x3 tag 2 data 0x22 → bypass 0x22 busy=0 that cycle; busy_count=0 after the edge.
- Same cycle: issue x4 tag 5 and commit wb x4 (not busy) data 0x33 → regs[4]=0x33, busy[4]=1 tag 5, busy_count=1.
- Issue x0 tag 1, wb x0 data 0xFF → x0 reads 0, busy 0, busy_count unchanged.
- Issue x1..x6 distinct tags, then flush with a same-cycle issue of x7 → busy_count=0, x7 not busy, all tags 0.
- With rdy_in=0: issue, wb and flush pulses produce no state change. Assert rst mid-sequence with 3 busy registers → immediate zero outputs and busy_count=0.
